// File: rtl/vga_sync_decoder.sv
// Receive-side VGA timing decoder: measures hsync line length and pulse width,
// tracks horizontal lock and recovers per-pixel coordinates on 25 MHz ticks.
module vga_sync_decoder #(
  parameter int unsigned H_TOTAL         = 800,
  parameter int unsigned H_SYNC          = 96,
  parameter int unsigned LOCK_LINES      = 4,
  parameter bit          SYNC_ACTIVE_LOW = 1'b1,
  parameter int unsigned CNT_W           = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_25Mhz,
  input  logic             horizontal_sync,
  input  logic             vertical_sync,
  input  logic             display_sync,
  output logic [CNT_W-1:0] pixel_x,
  output logic [CNT_W-1:0] pixel_y,
  output logic             pixel_valid,
  output logic             line_start,
  output logic [CNT_W-1:0] line_length,
  output logic             h_locked,
  output logic             sync_error
);

  localparam int unsigned TIMEOUT = 2 * H_TOTAL - 1;
  localparam int unsigned GOOD_W  = (LOCK_LINES < 1) ? 1 : $clog2(LOCK_LINES + 1);

  localparam logic [1:0] ST_SEARCH = 2'd0;
  localparam logic [1:0] ST_TRACK  = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  // Counters saturate at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  logic             clk25_q, clk25_d;
  logic             h_prev_q, h_prev_d;
  logic             v_prev_q, v_prev_d;
  logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
  logic [CNT_W-1:0] w_cnt_q, w_cnt_d;
  logic             width_ok_q, width_ok_d;
  logic [1:0]       state_q, state_d;
  logic [GOOD_W-1:0] good_q, good_d;
  logic [CNT_W-1:0] disp_cnt_q, disp_cnt_d;
  logic [CNT_W-1:0] y_cnt_q, y_cnt_d;
  logic [CNT_W-1:0] pixel_x_q, pixel_x_d;
  logic [CNT_W-1:0] pixel_y_q, pixel_y_d;
  logic             pixel_valid_q, pixel_valid_d;
  logic             line_start_q, line_start_d;
  logic [CNT_W-1:0] line_length_q, line_length_d;
  logic             h_locked_q, h_locked_d;
  logic             sync_error_q, sync_error_d;

  logic             tick_c;
  logic             h_act_c, v_act_c;
  logic             h_le_c, h_te_c, v_le_c;
  logic [CNT_W-1:0] meas_len_c;
  logic             good_line_c;
  logic [GOOD_W-1:0] good_inc_c;
  logic [CNT_W-1:0] disp_base_c;

  // Tick = rising edge of the divided pixel clock, seen as data on clk.
  assign tick_c  = clk_25Mhz & ~clk25_q;
  assign h_act_c = horizontal_sync ^ SYNC_ACTIVE_LOW;
  assign v_act_c = vertical_sync ^ SYNC_ACTIVE_LOW;
  assign h_le_c  = tick_c & h_act_c & ~h_prev_q;
  assign h_te_c  = tick_c & ~h_act_c & h_prev_q;
  assign v_le_c  = tick_c & v_act_c & ~v_prev_q;

  // Length of the line closed by this LE includes the LE tick itself.
  assign meas_len_c  = h_cnt_q + CNT_W'(1);
  assign good_line_c = (32'(meas_len_c) == H_TOTAL) && width_ok_q;
  assign good_inc_c  = good_q + GOOD_W'(1);

  always_comb begin
    clk25_d       = clk_25Mhz;
    h_prev_d      = h_prev_q;
    v_prev_d      = v_prev_q;
    h_cnt_d       = h_cnt_q;
    w_cnt_d       = w_cnt_q;
    width_ok_d    = width_ok_q;
    state_d       = state_q;
    good_d        = good_q;
    disp_cnt_d    = disp_cnt_q;
    y_cnt_d       = y_cnt_q;
    pixel_x_d     = pixel_x_q;
    pixel_y_d     = pixel_y_q;
    pixel_valid_d = 1'b0;
    line_start_d  = 1'b0;
    line_length_d = line_length_q;
    sync_error_d  = 1'b0;
    disp_base_c   = disp_cnt_q;

    if (tick_c) begin
      h_prev_d = h_act_c;
      v_prev_d = v_act_c;

      if (h_le_c) begin
        h_cnt_d       = '0;
        w_cnt_d       = CNT_W'(1);
        line_start_d  = 1'b1;
        line_length_d = meas_len_c;
        disp_base_c   = '0;
        disp_cnt_d    = '0;
        if (disp_cnt_q != '0) begin
          y_cnt_d = sat_inc(y_cnt_q);
        end

        case (state_q)
          ST_SEARCH: begin
            state_d = ST_TRACK;
            good_d  = '0;
          end
          ST_TRACK: begin
            if (good_line_c) begin
              good_d = good_inc_c;
              if (32'(good_inc_c) >= LOCK_LINES) begin
                state_d = ST_LOCKED;
              end
            end else begin
              good_d       = '0;
              sync_error_d = 1'b1;
            end
          end
          ST_LOCKED: begin
            if (!good_line_c) begin
              state_d      = ST_TRACK;
              good_d       = '0;
              sync_error_d = 1'b1;
            end
          end
          default: begin
            state_d = ST_SEARCH;
            good_d  = '0;
          end
        endcase
      end else begin
        h_cnt_d = sat_inc(h_cnt_q);
        if (h_act_c) begin
          w_cnt_d = sat_inc(w_cnt_q);
        end
        if (h_te_c) begin
          width_ok_d = (32'(w_cnt_q) == H_SYNC);
        end
        // Lost hsync: drop back to SEARCH silently.
        if ((state_q != ST_SEARCH) && (32'(h_cnt_d) >= TIMEOUT)) begin
          state_d = ST_SEARCH;
          good_d  = '0;
        end
      end

      // Frame start overrides any row advance from the same tick.
      if (v_le_c) begin
        y_cnt_d = '0;
      end

      if (display_sync) begin
        pixel_x_d     = disp_base_c;
        pixel_y_d     = y_cnt_d;
        disp_cnt_d    = sat_inc(disp_base_c);
        pixel_valid_d = (state_q == ST_LOCKED);
      end
    end

    h_locked_d = (state_d == ST_LOCKED);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk25_q       <= 1'b0;
      h_prev_q      <= 1'b0;
      v_prev_q      <= 1'b0;
      h_cnt_q       <= '0;
      w_cnt_q       <= '0;
      width_ok_q    <= 1'b0;
      state_q       <= ST_SEARCH;
      good_q        <= '0;
      disp_cnt_q    <= '0;
      y_cnt_q       <= '0;
      pixel_x_q     <= '0;
      pixel_y_q     <= '0;
      pixel_valid_q <= 1'b0;
      line_start_q  <= 1'b0;
      line_length_q <= '0;
      h_locked_q    <= 1'b0;
      sync_error_q  <= 1'b0;
    end else begin
      clk25_q       <= clk25_d;
      h_prev_q      <= h_prev_d;
      v_prev_q      <= v_prev_d;
      h_cnt_q       <= h_cnt_d;
      w_cnt_q       <= w_cnt_d;
      width_ok_q    <= width_ok_d;
      state_q       <= state_d;
      good_q        <= good_d;
      disp_cnt_q    <= disp_cnt_d;
      y_cnt_q       <= y_cnt_d;
      pixel_x_q     <= pixel_x_d;
      pixel_y_q     <= pixel_y_d;
      pixel_valid_q <= pixel_valid_d;
      line_start_q  <= line_start_d;
      line_length_q <= line_length_d;
      h_locked_q    <= h_locked_d;
      sync_error_q  <= sync_error_d;
    end
  end

  assign pixel_x     = pixel_x_q;
  assign pixel_y     = pixel_y_q;
  assign pixel_valid = pixel_valid_q;
  assign line_start  = line_start_q;
  assign line_length = line_length_q;
  assign h_locked    = h_locked_q;
  assign sync_error  = sync_error_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Scoreboard bench for vga_sync_decoder: directed lines push expected LE and
// pixel events; a negedge monitor pops and compares whenever the DUT pulses.
module tb_vga_sync_decoder;

  localparam int unsigned CNT_W = 11;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             clk_25Mhz = 1'b0;
  logic             horizontal_sync = 1'b1;
  logic             vertical_sync = 1'b1;
  logic             display_sync = 1'b0;
  logic [CNT_W-1:0] pixel_x;
  logic [CNT_W-1:0] pixel_y;
  logic             pixel_valid;
  logic             line_start;
  logic [CNT_W-1:0] line_length;
  logic             h_locked;
  logic             sync_error;

  vga_sync_decoder #(
    .H_TOTAL(800), .H_SYNC(96), .LOCK_LINES(4), .SYNC_ACTIVE_LOW(1'b1), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .clk_25Mhz(clk_25Mhz),
    .horizontal_sync(horizontal_sync), .vertical_sync(vertical_sync),
    .display_sync(display_sync),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .pixel_valid(pixel_valid),
    .line_start(line_start), .line_length(line_length),
    .h_locked(h_locked), .sync_error(sync_error)
  );

  always #5 clk = ~clk;

  typedef struct { int len; int err; int lock; } line_exp_t;
  typedef struct { int x; int y; } pix_exp_t;

  line_exp_t lq[$];
  pix_exp_t  pq[$];
  line_exp_t mon_le;
  pix_exp_t  mon_pe;
  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One pixel tick: syncs are active-low, display is active-high.
  task automatic do_tick(input bit h_act, input bit v_act, input bit disp);
    @(posedge clk); #1;
    horizontal_sync = ~h_act;
    vertical_sync   = ~v_act;
    display_sync    = disp;
    clk_25Mhz       = 1'b1;
    @(posedge clk); #1;
    clk_25Mhz = 1'b0;
  endtask

  // Line starts with an hsync LE; e_* describe the outputs of that LE.
  task automatic send_line(input int len, input int hw, input bit dsp, input bit vs,
                           input bit pix, input int y,
                           input int e_len, input int e_err, input int e_lock);
    line_exp_t le;
    pix_exp_t  pe;
    for (int t = 0; t < len; t++) begin
      bit d;
      d = dsp && (t >= 144) && (t < 784);
      if (t == 0) begin
        le.len = e_len; le.err = e_err; le.lock = e_lock;
        lq.push_back(le);
      end
      if (d && pix) begin
        pe.x = t - 144; pe.y = y;
        pq.push_back(pe);
      end
      do_tick(t < hw, vs && (t < 2), d);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pixel_x"}, int'(pixel_x), 0);
    check({tag, "_pixel_y"}, int'(pixel_y), 0);
    check({tag, "_pixel_valid"}, int'(pixel_valid), 0);
    check({tag, "_line_start"}, int'(line_start), 0);
    check({tag, "_line_length"}, int'(line_length), 0);
    check({tag, "_h_locked"}, int'(h_locked), 0);
    check({tag, "_sync_error"}, int'(sync_error), 0);
  endtask

  // Monitor: every DUT pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (line_start) begin
        if (lq.size() == 0) begin
          checks++; failures++;
          $display("FAIL line_start: unexpected pulse, length %0d at %0t", line_length, $time);
        end else begin
          mon_le = lq.pop_front();
          check("line_length", int'(line_length), mon_le.len);
          check("sync_error", int'(sync_error), mon_le.err);
          check("h_locked", int'(h_locked), mon_le.lock);
        end
      end else if (sync_error) begin
        checks++; failures++;
        $display("FAIL sync_error: pulse without line_start at %0t", $time);
      end
      if (pixel_valid) begin
        if (pq.size() == 0) begin
          checks++; failures++;
          $display("FAIL pixel_valid: unexpected pulse x=%0d y=%0d at %0t", pixel_x, pixel_y, $time);
        end else begin
          mon_pe = pq.pop_front();
          check("pixel_x", int'(pixel_x), mon_pe.x);
          check("pixel_y", int'(pixel_y), mon_pe.y);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst = 1'b1;
    #2 check_all_zero("por");
    @(posedge clk); #1 rst = 1'b0;

    // Acquire lock: first LE only enters TRACK; 5th LE locks.
    send_line(800, 96, 1, 0, 0, 0,   1, 0, 0);
    send_line(800, 96, 0, 0, 0, 0, 800, 0, 0);
    send_line(800, 96, 0, 0, 0, 0, 800, 0, 0);
    send_line(800, 96, 0, 0, 0, 0, 800, 0, 0);
    send_line(800, 96, 1, 0, 1, 1, 800, 0, 1);
    send_line(800, 96, 1, 0, 1, 2, 800, 0, 1);
    // vsync LE coincident with hsync LE restarts rows at 0.
    send_line(800, 96, 1, 1, 1, 0, 800, 0, 1);
    send_line(800, 96, 1, 0, 1, 1, 800, 0, 1);
    send_line(799, 96, 1, 0, 1, 2, 800, 0, 1);
    // Short line detected, then relock after 4 good lines.
    send_line(800, 96, 0, 0, 0, 0, 799, 1, 0);
    send_line(800, 96, 0, 0, 0, 0, 800, 0, 0);
    send_line(800, 96, 0, 0, 0, 0, 800, 0, 0);
    send_line(800, 96, 0, 0, 0, 0, 800, 0, 0);
    send_line(800, 95, 0, 0, 0, 0, 800, 0, 1);
    // Narrow hsync detected at the closing LE.
    send_line(800, 96, 0, 0, 0, 0, 800, 1, 0);
    send_line(800, 96, 0, 0, 0, 0, 800, 0, 0);
    send_line(800, 96, 0, 0, 0, 0, 800, 0, 0);
    send_line(800, 96, 0, 0, 0, 0, 800, 0, 0);
    send_line(300, 96, 0, 0, 0, 0, 800, 0, 1);

    // Mid-line reset while locked: outputs clear without a clock edge.
    rst = 1'b1;
    #1 check_all_zero("midrst");
    lq.delete();
    pq.delete();
    @(posedge clk);
    @(posedge clk); #1 rst = 1'b0;

    send_line(800, 96, 0, 0, 0, 0,   1, 0, 0);
    send_line(800, 96, 0, 0, 0, 0, 800, 0, 0);
    send_line(800, 96, 0, 0, 0, 0, 800, 0, 0);
    send_line(800, 96, 0, 0, 0, 0, 800, 0, 0);
    // Locked LE, then hsync held inactive until the timeout tick.
    send_line(1599, 96, 0, 0, 0, 0, 800, 0, 1);
    check("timeout_pre_locked", int'(h_locked), 1);
    do_tick(1'b0, 1'b0, 1'b0);
    check("timeout_unlocked", int'(h_locked), 0);
    check("timeout_no_error", int'(sync_error), 0);
    do_tick(1'b0, 1'b0, 1'b0);
    check("timeout_stays_unlocked", int'(h_locked), 0);
    // Next LE re-enters TRACK; four good LEs relock.
    send_line(800, 96, 0, 0, 0, 0, 1601, 0, 0);
    send_line(800, 96, 0, 0, 0, 0, 800, 0, 0);
    send_line(800, 96, 0, 0, 0, 0, 800, 0, 0);
    send_line(800, 96, 0, 0, 0, 0, 800, 0, 0);
    send_line(10, 96, 0, 0, 0, 0, 800, 0, 1);
    do_tick(1'b0, 1'b0, 1'b0);
    do_tick(1'b0, 1'b0, 1'b0);

    check("line_queue_drained", lq.size(), 0);
    check("pixel_queue_drained", pq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
